// File: rtl/bp_fe_ras_stack.sv
// Return address stack storage: circular buffer with top-of-stack read,
// pointer checkpoint/restore, flush, and overflow/underflow event pulses.
module bp_fe_ras_stack #(
    parameter  int unsigned width_p      = 39,
    parameter  int unsigned els_p        = 16,
    localparam int unsigned ptr_width_lp = $clog2(els_p),
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    push_i,
    input  logic [width_p-1:0]      w_data_i,
    input  logic                    pop_i,
    output logic [width_p-1:0]      r_data_o,
    output logic                    v_o,

    output logic [ptr_width_lp-1:0] ckpt_ptr_o,
    output logic [cnt_width_lp-1:0] ckpt_cnt_o,
    input  logic                    restore_i,
    input  logic [ptr_width_lp-1:0] restore_ptr_i,
    input  logic [cnt_width_lp-1:0] restore_cnt_i,

    input  logic                    flush_i,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] tos_r, tos_n;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic                    overflow_r, overflow_n;
    logic                    underflow_r, underflow_n;

    logic                    we;
    logic [ptr_width_lp-1:0] waddr;
    logic                    empty;
    logic                    full;

    assign empty = (cnt_r == '0);
    assign full  = (cnt_r == full_cnt_lp);

    // Next-state for pointer, count and event flags; flush > restore > push/pop
    always_comb begin
        tos_n       = tos_r;
        cnt_n       = cnt_r;
        overflow_n  = 1'b0;
        underflow_n = 1'b0;
        we          = 1'b0;
        waddr       = tos_r;

        if (flush_i) begin
            tos_n = '0;
            cnt_n = '0;
        end else if (restore_i) begin
            tos_n = restore_ptr_i;
            cnt_n = (restore_cnt_i > full_cnt_lp) ? full_cnt_lp : restore_cnt_i;
        end else if (push_i && (!pop_i || empty)) begin
            // Plain push (or push+pop on an empty stack): advance and write
            tos_n      = tos_r + ptr_width_lp'(1);
            waddr      = tos_r + ptr_width_lp'(1);
            we         = 1'b1;
            overflow_n = full && !pop_i;
            cnt_n      = full ? cnt_r : cnt_r + cnt_width_lp'(1);
        end else if (push_i) begin
            // Push+pop on a non-empty stack replaces the top entry in place
            we    = 1'b1;
            waddr = tos_r;
        end else if (pop_i) begin
            if (empty) begin
                underflow_n = 1'b1;
            end else begin
                tos_n = tos_r - ptr_width_lp'(1);
                cnt_n = cnt_r - cnt_width_lp'(1);
            end
        end
    end

    // Pointer, count and event flag registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tos_r       <= '0;
            cnt_r       <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            tos_r       <= tos_n;
            cnt_r       <= cnt_n;
            overflow_r  <= overflow_n;
            underflow_r <= underflow_n;
        end
    end

    // Entry storage; contents survive reset and are masked by the count
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_r[waddr] <= w_data_i;
        end
    end

    assign r_data_o    = empty ? '0 : mem_r[tos_r];
    assign v_o         = !empty;
    assign ckpt_ptr_o  = tos_r;
    assign ckpt_cnt_o  = cnt_r;
    assign overflow_o  = overflow_r;
    assign underflow_o = underflow_r;

endmodule

// File: tb/tb_bp_fe_ras_stack.sv
// Self-checking bench for bp_fe_ras_stack: directed scenarios with literal
// expectations plus randomized traffic against a behavioural stack model.
module tb_bp_fe_ras_stack;

    localparam int W   = 39;
    localparam int ELS = 4;
    localparam int PW  = 2;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          push = 1'b0;
    logic [W-1:0]  w_data = '0;
    logic          pop = 1'b0;
    logic [W-1:0]  r_data;
    logic          v;
    logic [PW-1:0] ckpt_ptr;
    logic [CW-1:0] ckpt_cnt;
    logic          restore = 1'b0;
    logic [PW-1:0] restore_ptr = '0;
    logic [CW-1:0] restore_cnt = '0;
    logic          flush = 1'b0;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    bp_fe_ras_stack #(.width_p(W), .els_p(ELS)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .push_i        (push),
        .w_data_i      (w_data),
        .pop_i         (pop),
        .r_data_o      (r_data),
        .v_o           (v),
        .ckpt_ptr_o    (ckpt_ptr),
        .ckpt_cnt_o    (ckpt_cnt),
        .restore_i     (restore),
        .restore_ptr_i (restore_ptr),
        .restore_cnt_i (restore_cnt),
        .flush_i       (flush),
        .overflow_o    (overflow),
        .underflow_o   (underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: a plain array with integer top index and count
    logic [W-1:0] m_mem [ELS];
    int           m_tos = 0;
    int           m_cnt = 0;
    bit           m_ovf = 0;
    bit           m_unf = 0;

    initial for (int i = 0; i < ELS; i++) m_mem[i] = '0;

    task automatic model_reset();
        m_tos = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    always @(posedge clk) begin
        if (reset_n) begin
            m_ovf = 0;
            m_unf = 0;
            if (flush) begin
                m_tos = 0;
                m_cnt = 0;
            end else if (restore) begin
                m_tos = int'(restore_ptr);
                m_cnt = (int'(restore_cnt) > ELS) ? ELS : int'(restore_cnt);
            end else if (push && (!pop || m_cnt == 0)) begin
                m_tos = (m_tos + 1) % ELS;
                m_mem[m_tos] = w_data;
                if (m_cnt == ELS) m_ovf = !pop;
                else m_cnt = m_cnt + 1;
            end else if (push) begin
                m_mem[m_tos] = w_data;
            end else if (pop) begin
                if (m_cnt == 0) m_unf = 1;
                else begin
                    m_tos = (m_tos + ELS - 1) % ELS;
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [W-1:0] exp_r;
        exp_r = (m_cnt == 0) ? '0 : m_mem[m_tos];
        check("model_r_data", r_data, exp_r);
        check("model_v", W'(v), W'(m_cnt != 0));
        check("model_ptr", W'(ckpt_ptr), W'(m_tos));
        check("model_cnt", W'(ckpt_cnt), W'(m_cnt));
        check("model_ovf", W'(overflow), W'(m_ovf));
        check("model_unf", W'(underflow), W'(m_unf));
    end

    // Drive one cycle of inputs, then return to idle just after the edge
    task automatic cyc(input bit p, input logic [W-1:0] d, input bit o,
                       input bit rs, input int rp, input int rc, input bit fl);
        push        = p;
        w_data      = d;
        pop         = o;
        restore     = rs;
        restore_ptr = PW'(rp);
        restore_cnt = CW'(rc);
        flush       = fl;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        restore = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic do_push(input logic [W-1:0] d);
        cyc(1, d, 0, 0, 0, 0, 0);
    endtask

    task automatic do_pop();
        cyc(0, '0, 1, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic sync_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] cp_ptr;
        logic [CW-1:0] cp_cnt;

        // Reset then idle
        #12;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_r_data", r_data, '0);
        check("rst_v", W'(v), '0);
        check("rst_ptr", W'(ckpt_ptr), '0);
        check("rst_cnt", W'(ckpt_cnt), '0);

        // LIFO order
        do_push(39'h100);
        do_push(39'h104);
        do_push(39'h108);
        @(negedge clk);
        check("lifo_cnt3", W'(ckpt_cnt), W'(3));
        check("lifo_top0", r_data, 39'h108);
        do_pop();
        @(negedge clk);
        check("lifo_top1", r_data, 39'h104);
        do_pop();
        @(negedge clk);
        check("lifo_top2", r_data, 39'h100);
        do_pop();
        @(negedge clk);
        check("lifo_empty_r", r_data, '0);
        check("lifo_empty_v", W'(v), '0);
        check("lifo_cnt0", W'(ckpt_cnt), '0);

        // Overflow wraps over the oldest entry
        for (int i = 1; i <= 5; i++) do_push(W'(i * 16));
        @(negedge clk);
        check("ovf_pulse", W'(overflow), W'(1));
        check("ovf_cnt", W'(ckpt_cnt), W'(4));
        idle();
        @(negedge clk);
        check("ovf_one_cycle", W'(overflow), '0);
        for (int i = 5; i >= 2; i--) begin
            check("ovf_pop_order", r_data, W'(i * 16));
            do_pop();
            @(negedge clk);
        end
        check("ovf_lost_oldest", W'(v), '0);

        // Underflow and replace-top
        do_pop();
        @(negedge clk);
        check("unf_pulse", W'(underflow), W'(1));
        check("unf_cnt", W'(ckpt_cnt), '0);
        idle();
        @(negedge clk);
        check("unf_one_cycle", W'(underflow), '0);
        cyc(1, 39'h200, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("pp_empty_r", r_data, 39'h200);
        check("pp_empty_cnt", W'(ckpt_cnt), W'(1));
        cyc(1, 39'h300, 1, 0, 0, 0, 0);
        @(negedge clk);
        check("pp_replace_r", r_data, 39'h300);
        check("pp_replace_cnt", W'(ckpt_cnt), W'(1));
        check("pp_no_ovf", W'(overflow), '0);

        // Checkpoint and restore
        sync_reset();
        do_push(39'hA);
        do_push(39'hB);
        @(negedge clk);
        cp_ptr = ckpt_ptr;
        cp_cnt = ckpt_cnt;
        check("ckpt_ptr", W'(cp_ptr), W'(2));
        check("ckpt_cnt", W'(cp_cnt), W'(2));
        do_pop();
        do_push(39'hC);
        cyc(1, 39'hDEAD, 0, 1, int'(cp_ptr), int'(cp_cnt), 0);
        @(negedge clk);
        check("restore_cnt", W'(ckpt_cnt), W'(2));
        check("restore_ptr", W'(ckpt_ptr), W'(2));
        check("restore_r", r_data, 39'hC);
        cyc(0, '0, 0, 1, 1, 7, 0);
        @(negedge clk);
        check("restore_sat", W'(ckpt_cnt), W'(4));

        // Asynchronous reset between edges
        do_push(39'h55);
        do_push(39'h66);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_v", W'(v), '0);
        check("async_r", r_data, '0);
        #1;
        reset_n = 1'b1;

        // Flush beats restore and push
        do_push(39'h77);
        do_push(39'h88);
        cyc(1, 39'h99, 0, 1, 1, 3, 1);
        @(negedge clk);
        check("flush_cnt", W'(ckpt_cnt), '0);
        check("flush_v", W'(v), '0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit p, o, rs, fl;
            p  = ($urandom_range(0, 1) == 1);
            o  = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 15) == 0);
            fl = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1;
                reset_n = 1'b0;
                model_reset();
                #2;
                reset_n = 1'b1;
            end
            cyc(p, {$urandom, $urandom}, o, rs, int'($urandom_range(0, ELS - 1)),
                int'($urandom_range(0, 7)), fl);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
